mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit between EX and the memory bus; optional misalignment trap via MEM_MISALIGN_TRAP_EN
`ifndef AluOpBus
`define AluOpBus   7:0
`endif
`ifndef RegBus
`define RegBus     31:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef ZeroWord
`define ZeroWord   32'h0000_0000
`endif
`ifndef EX_LB_OP
`define EX_LB_OP   8'b1110_0000
`define EX_LH_OP   8'b1110_0001
`define EX_LW_OP   8'b1110_0011
`define EX_LBU_OP  8'b1110_0100
`define EX_LHU_OP  8'b1110_0101
`define EX_SB_OP   8'b1110_1000
`define EX_SH_OP   8'b1110_1001
`define EX_SW_OP   8'b1110_1011
`endif

module mem_lsu #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [`AluOpBus]   aluop_i,
    input  logic [`RegBus]     wdata_i,
    input  logic [`RegBus]     reg2_i,
    input  logic [`RegAddrBus] wd_i,
    input  logic               wreg_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [31:0]        mem_addr_o,
    output logic [3:0]         mem_sel_o,
    output logic [31:0]        mem_wdata_o,
    input  logic               mem_ack_i,
    input  logic [31:0]        mem_rdata_i,
    output logic [`RegAddrBus] wd_o,
    output logic               wreg_o,
    output logic [`RegBus]     wdata_o,
    output logic               stallreq_o,
    output logic               err_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [3:0]         mem_sel_q, mem_sel_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [`RegAddrBus] wd_q, wd_d;
    logic               wreg_q, wreg_d;
    logic [`RegBus]     wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [`AluOpBus]   op_q, op_d;
    logic [1:0]         off_q, off_d;

    logic        op_byte, op_half, op_word, op_store, op_mem;
    logic [1:0]  off_eff;
    logic        trap_c;
    logic [3:0]  sel_c;
    logic [31:0] st_data_c;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data_c;
    logic        ld_q;

    always_comb begin
        op_byte  = (aluop_i == `EX_LB_OP) || (aluop_i == `EX_LBU_OP) || (aluop_i == `EX_SB_OP);
        op_half  = (aluop_i == `EX_LH_OP) || (aluop_i == `EX_LHU_OP) || (aluop_i == `EX_SH_OP);
        op_word  = (aluop_i == `EX_LW_OP) || (aluop_i == `EX_SW_OP);
        op_store = (aluop_i == `EX_SB_OP) || (aluop_i == `EX_SH_OP) || (aluop_i == `EX_SW_OP);
        op_mem   = op_byte || op_half || op_word;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        off_eff = wdata_i[1:0];
        trap_c  = (op_half && wdata_i[0]) || (op_word && (wdata_i[1:0] != 2'b00));
    end
`else
    // Misaligned low bits are silently dropped so the access stays naturally aligned.
    always_comb begin
        off_eff = 2'b00;
        if (op_byte)      off_eff = wdata_i[1:0];
        else if (op_half) off_eff = {wdata_i[1], 1'b0};
        trap_c  = 1'b0;
    end
`endif

    always_comb begin
        sel_c     = 4'b1111;
        st_data_c = reg2_i;
        if (op_byte) begin
            sel_c     = 4'b0001 << off_eff;
            st_data_c = {4{reg2_i[7:0]}};
        end else if (op_half) begin
            sel_c     = 4'b0011 << {off_eff[1], 1'b0};
            st_data_c = {2{reg2_i[15:0]}};
        end
    end

    always_comb begin
        ld_byte   = mem_rdata_i[{off_q, 3'b000} +: 8];
        ld_half   = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
        ld_q      = (op_q == `EX_LB_OP) || (op_q == `EX_LBU_OP) || (op_q == `EX_LH_OP) ||
                    (op_q == `EX_LHU_OP) || (op_q == `EX_LW_OP);
        ld_data_c = mem_rdata_i;
        case (op_q)
            `EX_LB_OP:  ld_data_c = {{24{ld_byte[7]}}, ld_byte};
            `EX_LBU_OP: ld_data_c = {24'h000000, ld_byte};
            `EX_LH_OP:  ld_data_c = {{16{ld_half[15]}}, ld_half};
            `EX_LHU_OP: ld_data_c = {16'h0000, ld_half};
            default:    ld_data_c = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_sel_d   = mem_sel_q;
        mem_wdata_d = mem_wdata_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        err_d       = 1'b0;
        op_d        = op_q;
        off_d       = off_q;
        stallreq_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!valid_i) begin
                    wreg_d = 1'b0;
                end else if (!op_mem) begin
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    wdata_d = wdata_i;
                end else begin
                    stallreq_o = 1'b1;
                    wreg_d     = 1'b0;
                    wd_d       = wd_i;
                    op_d       = aluop_i;
                    off_d      = off_eff;
                    if (trap_c) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d     = BUSY;
                        cnt_d       = 8'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = op_store;
                        mem_addr_d  = {wdata_i[31:2], 2'b00};
                        mem_sel_d   = sel_c;
                        mem_wdata_d = st_data_c;
                    end
                end
            end
            BUSY: begin
                stallreq_o = 1'b1;
                cnt_d      = cnt_q + 8'd1;
                if (mem_ack_i) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    wd_d      = wd_i;
                    wreg_d    = ld_q && wreg_i;
                    if (ld_q) wdata_d = ld_data_c;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    wreg_d    = 1'b0;
                    err_d     = 1'b1;
                end
            end
            RESP: begin
                // Result was visible for exactly this cycle; drop wreg so it is not written twice.
                state_d = IDLE;
                cnt_d   = 8'd0;
                wreg_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= `ZeroWord;
            mem_sel_q   <= 4'b0000;
            mem_wdata_q <= `ZeroWord;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            wdata_q     <= `ZeroWord;
            err_q       <= 1'b0;
            op_q        <= '0;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_sel_q   <= mem_sel_d;
            mem_wdata_q <= mem_wdata_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            op_q        <= op_d;
            off_q       <= off_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_sel_o   = mem_sel_q;
    assign mem_wdata_o = mem_wdata_q;
    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign wdata_o     = wdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
`timescale 1ns/1ps
module tb_mem_lsu;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_OR  = 8'b0010_0101;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [7:0]  aluop_i = 8'h00;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] reg2_i = 32'h0;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        mem_req_o, mem_we_o, wreg_o, stallreq_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wdata_o;
    logic [3:0]  mem_sel_o;
    logic [4:0]  wd_o;

    int checks = 0;
    int failures = 0;
    int stall_total = 0;
    int req_total = 0;
    int snap_s, snap_r;

    mem_lsu #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
        .wdata_i(wdata_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_o(stallreq_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        stall_total <= stall_total + int'(stallreq_o);
        req_total   <= req_total + int'(mem_req_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] wd, input logic wr);
        valid_i = 1'b1; aluop_i = op; wdata_i = a; reg2_i = d; wd_i = wd; wreg_i = wr;
    endtask

    initial begin
        #2;
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_wreg", {31'd0, wreg_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_sel", {28'd0, mem_sel_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_wd", {27'd0, wd_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // pass-through, then a bubble
        tick();
        drive(OP_OR, 32'h0000_55AA, 32'h0, 5'd5, 1'b1);
        @(negedge clk);
        check("pt_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        check("pt_wdata", wdata_o, 32'h0000_55AA);
        check("pt_wd", {27'd0, wd_o}, 32'd5);
        check("pt_wreg", {31'd0, wreg_o}, 32'd1);
        tick();
        @(negedge clk);
        check("bubble_wreg", {31'd0, wreg_o}, 32'd0);
        check("bubble_hold", wdata_o, 32'h0000_55AA);

        // LW 0x100, ack in the third BUSY cycle
        tick();
        drive(OP_LW, 32'h0000_0100, 32'h0, 5'd7, 1'b1);
        @(negedge clk);
        check("lw_stall_comb", {31'd0, stallreq_o}, 32'd1);
        check("lw_wb_cleared", {31'd0, wreg_o}, 32'd0);
        snap_s = stall_total;
        tick();
        @(negedge clk);
        check("lw_req", {31'd0, mem_req_o}, 32'd1);
        check("lw_sel", {28'd0, mem_sel_o}, 32'h0000_000F);
        check("lw_addr", mem_addr_o, 32'h0000_0100);
        check("lw_we", {31'd0, mem_we_o}, 32'd0);
        tick();
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0; valid_i = 1'b0;
        @(negedge clk);
        check("lw_stall_cycles", 32'(stall_total - snap_s), 32'd4);
        check("lw_resp_stall", {31'd0, stallreq_o}, 32'd0);
        check("lw_resp_req", {31'd0, mem_req_o}, 32'd0);
        check("lw_wdata", wdata_o, 32'hDEAD_BEEF);
        check("lw_wreg", {31'd0, wreg_o}, 32'd1);
        check("lw_wd", {27'd0, wd_o}, 32'd7);
        tick();
        @(negedge clk);
        check("lw_after_wreg", {31'd0, wreg_o}, 32'd0);

        // LB / LBU at 0x103
        drive(OP_LB, 32'h0000_0103, 32'h0, 5'd3, 1'b1);
        tick();
        @(negedge clk);
        check("lb_sel", {28'd0, mem_sel_o}, 32'h0000_0008);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h8000_0000;
        tick();
        mem_ack_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        check("lb_wdata", wdata_o, 32'hFFFF_FF80);
        check("lb_wreg", {31'd0, wreg_o}, 32'd1);
        tick();
        drive(OP_LBU, 32'h0000_0103, 32'h0, 5'd3, 1'b1);
        tick();
        @(negedge clk);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h8000_0000;
        tick();
        mem_ack_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        check("lbu_wdata", wdata_o, 32'h0000_0080);
        tick();

        // SH at 0x102
        drive(OP_SH, 32'h0000_0102, 32'h1234_ABCD, 5'd9, 1'b1);
        tick();
        @(negedge clk);
        check("sh_sel", {28'd0, mem_sel_o}, 32'h0000_000C);
        check("sh_wdata", mem_wdata_o, 32'hABCD_ABCD);
        check("sh_we", {31'd0, mem_we_o}, 32'd1);
        check("sh_addr", mem_addr_o, 32'h0000_0100);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        check("sh_wreg", {31'd0, wreg_o}, 32'd0);
        tick();

        // LW with no ack: timeout after 4 BUSY cycles
        drive(OP_LW, 32'h0000_0200, 32'h0, 5'd4, 1'b1);
        @(negedge clk);
        snap_r = req_total;
        tick(); tick(); tick(); tick(); tick();
        valid_i = 1'b0;
        @(negedge clk);
        check("to_req_cycles", 32'(req_total - snap_r), 32'd4);
        check("to_req_low", {31'd0, mem_req_o}, 32'd0);
        check("to_err", {31'd0, err_o}, 32'd1);
        check("to_wreg", {31'd0, wreg_o}, 32'd0);
        tick();
        @(negedge clk);
        check("to_err_pulse", {31'd0, err_o}, 32'd0);
        check("to_idle_stall", {31'd0, stallreq_o}, 32'd0);

        // LH at 0x101
        tick();
        drive(OP_LH, 32'h0000_0101, 32'h0, 5'd2, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        check("mis_req", {31'd0, mem_req_o}, 32'd0);
        check("mis_err", {31'd0, err_o}, 32'd1);
        check("mis_wreg", {31'd0, wreg_o}, 32'd0);
        tick();
`else
        tick();
        @(negedge clk);
        check("mis_sel", {28'd0, mem_sel_o}, 32'h0000_0003);
        check("mis_addr", mem_addr_o, 32'h0000_0100);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_F00F;
        tick();
        mem_ack_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        check("mis_wdata", wdata_o, 32'hFFFF_F00F);
        check("mis_err", {31'd0, err_o}, 32'd0);
        tick();
`endif

        // reset mid-BUSY, then a stale ack
        drive(OP_LW, 32'h0000_0300, 32'h0, 5'd6, 1'b1);
        tick();
        @(negedge clk);
        check("rb_req", {31'd0, mem_req_o}, 32'd1);
        rst = 1'b0;
        #1;
        check("rb_req_drop", {31'd0, mem_req_o}, 32'd0);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        tick();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("rb_wreg", {31'd0, wreg_o}, 32'd0);
        check("rb_req_idle", {31'd0, mem_req_o}, 32'd0);
        check("rb_stall", {31'd0, stallreq_o}, 32'd0);
        check("rb_wdata", wdata_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
